// File: rtl/neo_result_reader_if.sv
//==============================================================================
// Module      : neo_result_reader_if
// Description : Valid/ready result stream carrying a signed value, its memory
//               address and a spike flag.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface neo_result_reader_if #(
    parameter int N  = 16,
    parameter int AW = 5
);
    logic                out_valid;
    logic                out_ready;
    logic signed [N-1:0] out_data;
    logic [AW-1:0]       out_addr;
    logic                out_spike;

    modport master (
        output out_valid,
        output out_data,
        output out_addr,
        output out_spike,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_addr,
        input  out_spike,
        output out_ready
    );
endinterface

`default_nettype wire

// File: rtl/neo_result_reader.sv
//==============================================================================
// Module      : neo_result_reader
// Description : Drains an M-entry signed result memory in address order onto a
//               valid/ready stream, flagging values above a captured threshold.
//               Define NEO_SPIKE_COUNT_EN to build the per-frame spike counter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module neo_result_reader #(
    parameter  int N  = 16,
    parameter  int M  = 32,
    localparam int AW = (M > 1) ? $clog2(M) : 1
) (
    input  wire logic                Clk,
    input  wire logic                reset,
    input  wire logic                start,
    input  wire logic signed [N-1:0] threshold,
    output logic [AW-1:0]            raddr,
    input  wire logic signed [N-1:0] rdata,
    neo_result_reader_if.master      out,
    output logic                     busy,
    output logic                     done,
    output logic [AW:0]              spike_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(M - 1);

    state_t              state_q, state_d;
    logic [AW-1:0]       addr_q,  addr_d;
    logic signed [N-1:0] thr_q,   thr_d;
    logic signed [N-1:0] data_q,  data_d;
    logic [AW-1:0]       oaddr_q, oaddr_d;
    logic                spike_q, spike_d;

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            thr_q   <= '0;
            data_q  <= '0;
            oaddr_q <= '0;
            spike_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            thr_q   <= thr_d;
            data_q  <= data_d;
            oaddr_q <= oaddr_d;
            spike_q <= spike_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        thr_d   = thr_q;
        data_d  = data_q;
        oaddr_d = oaddr_q;
        spike_d = spike_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    thr_d   = threshold;
                    addr_d  = '0;
                    state_d = S_READ;
                end
            end
            S_READ: state_d = S_WAIT;
            S_WAIT: begin
                // rdata now reflects the address presented during READ
                data_d  = rdata;
                oaddr_d = addr_q;
                spike_d = (rdata > thr_q);
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (out.out_ready) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_READ;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign raddr         = addr_q;
    assign out.out_valid = (state_q == S_HOLD);
    assign out.out_data  = data_q;
    assign out.out_addr  = oaddr_q;
    assign out.out_spike = spike_q;
    assign busy          = (state_q == S_READ) || (state_q == S_WAIT) || (state_q == S_HOLD);
    assign done          = (state_q == S_DONE);

`ifdef NEO_SPIKE_COUNT_EN
    logic [AW:0] cnt_q, cnt_d;

    always_ff @(posedge Clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // At most M accepted beats per frame, so AW+1 bits can never wrap
    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == S_IDLE) && start) begin
            cnt_d = '0;
        end else if ((state_q == S_HOLD) && out.out_ready && spike_q) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign spike_count = cnt_q;
`else
    assign spike_count = '0;
`endif

endmodule

`default_nettype wire

// File: doc/neo_result_reader.md
# neo_result_reader

- Drains a completed NEO result frame from the M-entry signed sample/result memory, one location at a time.
- Streams each value out on a valid/ready interface, tagged with its address and a per-sample spike flag (value strictly greater than a programmable signed threshold).
- Sits on the memory read port on the consumer side of `NEOcalculator`: the calculator writes results, this block reads them back out.

## Interface
Parameters:
- N, 16, sample/result width in bits (signed)
- M, 32, number of memory locations; address width AW = $clog2(M)

Ports:
- Clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  begin draining a frame (pulse; sampled only in IDLE)
- threshold  input  N  signed spike threshold, captured on accepted start
- raddr  output  AW  memory read address
- rdata  input  N  signed memory read data; valid the cycle after raddr is driven (registered read)
- out_valid  output  1  out_data/out_addr/out_spike valid
- out_ready  input  1  downstream accepts beat when out_valid && out_ready
- out_data  output  N  signed value read from memory
- out_addr  output  AW  address of out_data
- out_spike  output  1  out_data > captured threshold (signed)
- busy  output  1  high in READ, WAIT, HOLD
- done  output  1  one-cycle pulse after last beat accepted
- spike_count  output  AW+1  number of accepted beats with out_spike=1 in current/last frame

## Operation
- FSM states: IDLE, READ, WAIT, HOLD, DONE.
- IDLE: start=1 -> capture threshold, clear address counter and spike_count, go READ. Otherwise stay.
- READ: drive raddr = address counter -> WAIT.
- WAIT: register rdata into out_data, counter into out_addr, signed compare into out_spike -> HOLD.
- HOLD: out_valid=1; outputs held stable until out_ready=1. On accept: if out_spike, spike_count += 1. If counter == M-1 -> DONE; else counter += 1 -> READ.
- DONE: done=1 for exactly this cycle -> IDLE.
- start outside IDLE (including DONE) is ignored; threshold changes after capture have no effect.
- Compare is full-width signed; equality is not a spike. spike_count max value M, never wraps.
- Address counter never wraps mid-frame; frame always covers 0..M-1 in ascending order.
- Reset in any state: immediately to IDLE; takes priority over start.

## Timing
- Reset values: raddr=0, out_valid=0, out_data=0, out_addr=0, out_spike=0, busy=0, done=0, spike_count=0.
- start accepted at cycle T: READ at T+1 (raddr=0), WAIT at T+2, out_valid=1 at T+3.
- Per beat: 3 cycles minimum with out_ready held high (READ, WAIT, HOLD); full frame with no backpressure = 3M cycles + 1 DONE cycle.
- out_ready asserted with out_valid low has no effect; out_valid never drops without an accept except on reset.
- spike_count updates the cycle after the accepting edge.
- spike_count is final when done=1 and holds until the next accepted start or reset.

## Configuration
- Macro: NEO_SPIKE_COUNT_EN.
- Defined: spike_count counter is implemented as above.
- Undefined: no counter logic is built; spike_count is tied to 0. All other behaviour is identical.

## Test plan
- Frame + threshold: N=16, M=32, mem[i]=100*i, threshold=1500, out_ready=1 -> 32 beats with out_addr 0..31; out_spike=0 for i<=15 (1500 is not a spike), 1 for i>=16; spike_count=16; done pulses once at cycle 3*32+1 after start.
- Signed compare: mem[i]=-5 for all i, threshold=-10 -> every out_spike=1, spike_count=32. Threshold=-5 -> all out_spike=0, spike_count=0.
- Backpressure: deassert out_ready for 5 cycles at beat 7 -> out_valid, out_data, out_addr=7 and out_spike held stable; no beat lost or duplicated; spike_count unaffected until accept.
- Start handling: pulse start in HOLD and in DONE, and change threshold mid-frame -> ignored; no restart, original threshold used; second start in IDLE restarts at addr 0 with spike_count cleared.
- Reset mid-frame: assert reset during HOLD at beat 10 -> next cycle all outputs at reset values and state IDLE. A fresh start then drains all 32 beats correctly.
- Macro off: rerun the frame + threshold scenario without NEO_SPIKE_COUNT_EN -> identical beats and out_spike values; spike_count=0 throughout.
